// File: rtl/axi4_stream_upsize_gbx.sv
// Narrow-to-wide AXI4-Stream gearbox: packs RATIO input beats into one
// output beat, little-endian lane order. Partial words (early tlast) are
// zero-padded with tkeep/tstrb cleared on the unfilled lanes.
// Optional feature macro: GBX_PKT_CNT_EN adds pkt_cnt_o, a wrapping count
// of output words sent with tlast.
module axi4_stream_upsize_gbx #(
  parameter int DATA_WIDTH_IN = 16,
  parameter int RATIO         = 4,
  parameter int ID_WIDTH      = 1,
  parameter int DEST_WIDTH    = 1,
  parameter int USER_WIDTH    = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               pkt_i_tvalid,
  output logic                               pkt_i_tready,
  input  logic [DATA_WIDTH_IN-1:0]           pkt_i_tdata,
  input  logic [DATA_WIDTH_IN/8-1:0]         pkt_i_tkeep,
  input  logic [DATA_WIDTH_IN/8-1:0]         pkt_i_tstrb,
  input  logic [ID_WIDTH-1:0]                pkt_i_tid,
  input  logic [DEST_WIDTH-1:0]              pkt_i_tdest,
  input  logic [USER_WIDTH-1:0]              pkt_i_tuser,
  input  logic                               pkt_i_tlast,
  output logic                               pkt_o_tvalid,
  input  logic                               pkt_o_tready,
  output logic [DATA_WIDTH_IN*RATIO-1:0]     pkt_o_tdata,
  output logic [DATA_WIDTH_IN*RATIO/8-1:0]   pkt_o_tkeep,
  output logic [DATA_WIDTH_IN*RATIO/8-1:0]   pkt_o_tstrb,
  output logic [ID_WIDTH-1:0]                pkt_o_tid,
  output logic [DEST_WIDTH-1:0]              pkt_o_tdest,
  output logic [USER_WIDTH-1:0]              pkt_o_tuser,
  output logic                               pkt_o_tlast
`ifdef GBX_PKT_CNT_EN
  ,
  output logic [31:0]                        pkt_cnt_o
`endif
);

  localparam int DW = DATA_WIDTH_IN;
  localparam int KI = DATA_WIDTH_IN / 8;
  localparam int DO = DATA_WIDTH_IN * RATIO;
  localparam int KO = DO / 8;
  localparam int FW = $clog2(RATIO);

  logic [FW-1:0]           fill;
  logic                    first_word;
  logic [USER_WIDTH-1:0]   user_hold;
  logic [(RATIO-1)*DW-1:0] acc_data;
  logic [(RATIO-1)*KI-1:0] acc_keep;
  logic [(RATIO-1)*KI-1:0] acc_strb;

  logic                    fill_full;
  logic                    in_hs;
  logic                    word_done;
  logic                    out_hs;
  logic [DO-1:0]           word_data;
  logic [KO-1:0]           word_keep;
  logic [KO-1:0]           word_strb;
  logic [USER_WIDTH-1:0]   word_user;

  // A completing beat can only be taken if the output register is free or draining.
  assign fill_full    = (fill == FW'(RATIO - 1));
  assign pkt_i_tready = !(pkt_o_tvalid && !pkt_o_tready && (fill_full || pkt_i_tlast));
  assign in_hs        = pkt_i_tvalid && pkt_i_tready;
  assign word_done    = in_hs && (fill_full || pkt_i_tlast);
  assign out_hs       = pkt_o_tvalid && pkt_o_tready;

  // A single-beat first word never passes through user_hold.
  assign word_user = (fill == '0) ? pkt_i_tuser : user_hold;

  // Lanes below the fill point come from the accumulator, the current beat
  // takes lane 'fill', and lanes above it are zero (partial word).
  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    if (k < RATIO - 1) begin : g_acc
      assign word_data[k*DW +: DW] = (fill == FW'(k)) ? pkt_i_tdata :
                                     (fill >  FW'(k)) ? acc_data[k*DW +: DW] : '0;
      assign word_keep[k*KI +: KI] = (fill == FW'(k)) ? pkt_i_tkeep :
                                     (fill >  FW'(k)) ? acc_keep[k*KI +: KI] : '0;
      assign word_strb[k*KI +: KI] = (fill == FW'(k)) ? pkt_i_tstrb :
                                     (fill >  FW'(k)) ? acc_strb[k*KI +: KI] : '0;

      // Capture a non-completing beat into its accumulator lane.
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          acc_data[k*DW +: DW] <= '0;
          acc_keep[k*KI +: KI] <= '0;
          acc_strb[k*KI +: KI] <= '0;
        end else if (in_hs && !word_done && fill == FW'(k)) begin
          acc_data[k*DW +: DW] <= pkt_i_tdata;
          acc_keep[k*KI +: KI] <= pkt_i_tkeep;
          acc_strb[k*KI +: KI] <= pkt_i_tstrb;
        end
      end
    end else begin : g_top
      assign word_data[k*DW +: DW] = fill_full ? pkt_i_tdata : '0;
      assign word_keep[k*KI +: KI] = fill_full ? pkt_i_tkeep : '0;
      assign word_strb[k*KI +: KI] = fill_full ? pkt_i_tstrb : '0;
    end
  end

  // Fill position, first-word tracking and first-beat tuser capture.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fill       <= '0;
      first_word <= 1'b1;
      user_hold  <= '0;
    end else if (in_hs) begin
      fill <= word_done ? '0 : fill + 1'b1;
      if (word_done) first_word <= pkt_i_tlast;
      if (first_word && fill == '0) user_hold <= pkt_i_tuser;
    end
  end

  // Output register: loaded on completion, held while stalled.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pkt_o_tvalid <= 1'b0;
      pkt_o_tdata  <= '0;
      pkt_o_tkeep  <= '0;
      pkt_o_tstrb  <= '0;
      pkt_o_tid    <= '0;
      pkt_o_tdest  <= '0;
      pkt_o_tuser  <= '0;
      pkt_o_tlast  <= 1'b0;
    end else if (word_done) begin
      pkt_o_tvalid <= 1'b1;
      pkt_o_tdata  <= word_data;
      pkt_o_tkeep  <= word_keep;
      pkt_o_tstrb  <= word_strb;
      pkt_o_tid    <= pkt_i_tid;
      pkt_o_tdest  <= pkt_i_tdest;
      pkt_o_tuser  <= first_word ? word_user : '0;
      pkt_o_tlast  <= pkt_i_tlast;
    end else if (out_hs) begin
      pkt_o_tvalid <= 1'b0;
    end
  end

`ifdef GBX_PKT_CNT_EN
  // Count packets leaving the gearbox; wraps naturally at 32 bits.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) pkt_cnt_o <= '0;
    else if (out_hs && pkt_o_tlast) pkt_cnt_o <= pkt_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_axi4_stream_upsize_gbx.sv
// Directed bench for axi4_stream_upsize_gbx (default parameters, 16b x 4).
// Expected output words are queued when stimulus is built and checked by a
// monitor as the DUT hands them out; held output is checked while stalled.
module tb_axi4_stream_upsize_gbx;

  localparam int DW = 16;
  localparam int R  = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        pkt_i_tvalid = 1'b0;
  logic        pkt_i_tready;
  logic [15:0] pkt_i_tdata = '0;
  logic [1:0]  pkt_i_tkeep = '0;
  logic [1:0]  pkt_i_tstrb = '0;
  logic        pkt_i_tid = 1'b0;
  logic        pkt_i_tdest = 1'b0;
  logic        pkt_i_tuser = 1'b0;
  logic        pkt_i_tlast = 1'b0;
  logic        pkt_o_tvalid;
  logic        pkt_o_tready = 1'b1;
  logic [63:0] pkt_o_tdata;
  logic [7:0]  pkt_o_tkeep;
  logic [7:0]  pkt_o_tstrb;
  logic        pkt_o_tid;
  logic        pkt_o_tdest;
  logic        pkt_o_tuser;
  logic        pkt_o_tlast;
`ifdef GBX_PKT_CNT_EN
  logic [31:0] pkt_cnt_o;
`endif

  axi4_stream_upsize_gbx dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pkt_i_tvalid (pkt_i_tvalid),
    .pkt_i_tready (pkt_i_tready),
    .pkt_i_tdata  (pkt_i_tdata),
    .pkt_i_tkeep  (pkt_i_tkeep),
    .pkt_i_tstrb  (pkt_i_tstrb),
    .pkt_i_tid    (pkt_i_tid),
    .pkt_i_tdest  (pkt_i_tdest),
    .pkt_i_tuser  (pkt_i_tuser),
    .pkt_i_tlast  (pkt_i_tlast),
    .pkt_o_tvalid (pkt_o_tvalid),
    .pkt_o_tready (pkt_o_tready),
    .pkt_o_tdata  (pkt_o_tdata),
    .pkt_o_tkeep  (pkt_o_tkeep),
    .pkt_o_tstrb  (pkt_o_tstrb),
    .pkt_o_tid    (pkt_o_tid),
    .pkt_o_tdest  (pkt_o_tdest),
    .pkt_o_tuser  (pkt_o_tuser),
    .pkt_o_tlast  (pkt_o_tlast)
`ifdef GBX_PKT_CNT_EN
    ,
    .pkt_cnt_o    (pkt_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [7:0]  strb;
    logic        last;
    logic        user;
    logic        id;
    logic        dest;
  } exp_t;

  exp_t q[$];
  int   n_run = 0;
  int   n_fail = 0;
  int   acc_cnt = 0;
  int   wait_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] strb_of(input int i, input bit alt);
    return alt ? 2'(i % 3 + 1) : 2'b11;
  endfunction

  function automatic logic id_of(input int i);
    return (i % 2) == 1;
  endfunction

  function automatic logic dest_of(input int i);
    return ((i / 2) % 2) == 0;
  endfunction

  task automatic push_exp(input logic [63:0] d, input logic [7:0] k, input logic [7:0] s,
                          input logic l, input logic u, input logic id, input logic de);
    exp_t e;
    e.data = d; e.keep = k; e.strb = s; e.last = l; e.user = u; e.id = id; e.dest = de;
    q.push_back(e);
  endtask

  // Expected words for a packet of n beats, built by chunking the beat list.
  task automatic build_exp(input int n, input logic [15:0] base, input logic user0, input bit alt);
    exp_t e;
    int   last_i;
    int   i;
    for (int w = 0; w * R < n; w++) begin
      e.data = '0; e.keep = '0; e.strb = '0;
      last_i = w * R;
      for (int k = 0; k < R; k++) begin
        i = w * R + k;
        if (i < n) begin
          e.data[k*DW +: DW] = 16'(base + 16'(i));
          e.keep[k*2 +: 2]   = 2'b11;
          e.strb[k*2 +: 2]   = strb_of(i, alt);
          last_i = i;
        end
      end
      e.last = (last_i == n - 1);
      e.user = (w == 0) ? user0 : 1'b0;
      e.id   = id_of(last_i);
      e.dest = dest_of(last_i);
      q.push_back(e);
    end
  endtask

  // Drive n beats back to back; called and returns at posedge+1.
  task automatic drive_pkt(input int n, input logic [15:0] base, input logic user0,
                           input bit alt, input bit term);
    int waits;
    bit rdy;
    for (int i = 0; i < n; i++) begin
      pkt_i_tvalid = 1'b1;
      pkt_i_tdata  = 16'(base + 16'(i));
      pkt_i_tkeep  = 2'b11;
      pkt_i_tstrb  = strb_of(i, alt);
      pkt_i_tlast  = term && (i == n - 1);
      pkt_i_tuser  = (i == 0) ? user0 : ~user0;
      pkt_i_tid    = id_of(i);
      pkt_i_tdest  = dest_of(i);
      waits = 0;
      do begin
        @(negedge clk_i);
        rdy = pkt_i_tready;
        @(posedge clk_i);
        if (!rdy) waits++;
      end while (!rdy && waits < 100);
      wait_cnt += waits;
      if (!rdy) begin
        chk("hs_timeout", 64'(rdy), 64'd1);
        return;
      end
      acc_cnt++;
      #1;
    end
  endtask

  task automatic idle();
    pkt_i_tvalid = 1'b0;
    pkt_i_tlast  = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (q.size() > 0 && c < 200) begin
      @(posedge clk_i);
      c++;
    end
    @(posedge clk_i);
    #1;
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  logic [19:0] o_ctrl;
  assign o_ctrl = {pkt_o_tkeep, pkt_o_tstrb, pkt_o_tlast, pkt_o_tuser, pkt_o_tid, pkt_o_tdest};

  logic        stall_q = 1'b0;
  logic [63:0] h_data;
  logic [19:0] h_ctrl;

  // Output monitor: stability while stalled, scoreboard pop on handshake.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i) begin
      stall_q <= 1'b0;
    end else if (pkt_o_tvalid) begin
      if (stall_q) begin
        chk("hold_data", pkt_o_tdata, h_data);
        chk("hold_ctrl", 64'(o_ctrl), 64'(h_ctrl));
      end
      if (pkt_o_tready) begin
        chk("sb_has_entry", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("tdata", pkt_o_tdata, e.data);
          chk("tkeep", 64'(pkt_o_tkeep), 64'(e.keep));
          chk("tstrb", 64'(pkt_o_tstrb), 64'(e.strb));
          chk("tlast", 64'(pkt_o_tlast), 64'(e.last));
          chk("tuser", 64'(pkt_o_tuser), 64'(e.user));
          chk("tid",   64'(pkt_o_tid),   64'(e.id));
          chk("tdest", 64'(pkt_o_tdest), 64'(e.dest));
        end
      end
      stall_q <= !pkt_o_tready;
      h_data  <= pkt_o_tdata;
      h_ctrl  <= o_ctrl;
    end else begin
      stall_q <= 1'b0;
    end
  end

  initial begin
    int w0;
    int a0;
`ifdef GBX_PKT_CNT_EN
    logic [31:0] c0;
`endif

    // reset state
    #2;
    chk("rst_tvalid", 64'(pkt_o_tvalid), 64'd0);
    chk("rst_tdata",  pkt_o_tdata, 64'd0);
    chk("rst_ctrl",   64'(o_ctrl), 64'd0);
    chk("rst_tready", 64'(pkt_i_tready), 64'd1);
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // 8-beat packet, literal expected words, no input stalls
    push_exp(64'h0004_0003_0002_0001, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(64'h0008_0007_0006_0005, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    w0 = wait_cnt;
    drive_pkt(8, 16'h0001, 1'b0, 1'b0, 1'b1);
    chk("t1_no_stall", 64'(wait_cnt - w0), 64'd0);
    idle();
    drain();

    // 5-beat packet with partial second word, then a packet starting at lane 0
    push_exp(64'h00A4_00A3_00A2_00A1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(64'h0000_0000_0000_00A5, 8'h03, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1);
    drive_pkt(5, 16'h00A1, 1'b0, 1'b0, 1'b1);
    build_exp(4, 16'h00B0, 1'b1, 1'b1);
    drive_pkt(4, 16'h00B0, 1'b1, 1'b1, 1'b1);
    idle();
    drain();

    // tuser only on first word; next packets carry their own first-beat tuser
    build_exp(12, 16'h0200, 1'b1, 1'b1);
    drive_pkt(12, 16'h0200, 1'b1, 1'b1, 1'b1);
    build_exp(4, 16'h0210, 1'b0, 1'b0);
    drive_pkt(4, 16'h0210, 1'b0, 1'b0, 1'b1);
    build_exp(1, 16'h0220, 1'b1, 1'b1);
    drive_pkt(1, 16'h0220, 1'b1, 1'b1, 1'b1);
    idle();
    drain();

    // output backpressure for 10 cycles during continuous input
    pkt_o_tready = 1'b0;
    build_exp(12, 16'h0100, 1'b0, 1'b1);
    a0 = acc_cnt;
    fork
      drive_pkt(12, 16'h0100, 1'b0, 1'b1, 1'b1);
      begin
        repeat (10) @(posedge clk_i);
        #2;
        chk("bp_accepted", 64'(acc_cnt - a0), 64'd7);
        chk("bp_tready", 64'(pkt_i_tready), 64'd0);
        pkt_o_tready = 1'b1;
      end
    join
    idle();
    drain();

    // back-to-back packets of mixed length, no bubbles
    w0 = wait_cnt;
    build_exp(3, 16'h0500, 1'b1, 1'b1);
    drive_pkt(3, 16'h0500, 1'b1, 1'b1, 1'b1);
    build_exp(7, 16'h0510, 1'b0, 1'b1);
    drive_pkt(7, 16'h0510, 1'b0, 1'b1, 1'b1);
    build_exp(2, 16'h0520, 1'b1, 1'b0);
    drive_pkt(2, 16'h0520, 1'b1, 1'b0, 1'b1);
    chk("b2b_no_stall", 64'(wait_cnt - w0), 64'd0);
    idle();
    drain();

    // reset with a pending word and a half-filled accumulator
    pkt_o_tready = 1'b0;
    drive_pkt(6, 16'h0300, 1'b1, 1'b0, 1'b0);
    idle();
    #2 rst_i = 1'b0;
    #1;
    chk("arst_tvalid", 64'(pkt_o_tvalid), 64'd0);
    chk("arst_tdata",  pkt_o_tdata, 64'd0);
    chk("arst_ctrl",   64'(o_ctrl), 64'd0);
    q.delete();
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    pkt_o_tready = 1'b1;
    @(posedge clk_i);
    #1;
    build_exp(4, 16'h0400, 1'b0, 1'b1);
    drive_pkt(4, 16'h0400, 1'b0, 1'b1, 1'b1);
    idle();
    drain();

`ifdef GBX_PKT_CNT_EN
    // packet counter: three packets, then wrap from all-ones
    c0 = pkt_cnt_o;
    build_exp(1, 16'h0600, 1'b0, 1'b0);
    drive_pkt(1, 16'h0600, 1'b0, 1'b0, 1'b1);
    build_exp(4, 16'h0610, 1'b0, 1'b0);
    drive_pkt(4, 16'h0610, 1'b0, 1'b0, 1'b1);
    build_exp(9, 16'h0620, 1'b0, 1'b0);
    drive_pkt(9, 16'h0620, 1'b0, 1'b0, 1'b1);
    idle();
    drain();
    chk("cnt_three", 64'(pkt_cnt_o - c0), 64'd3);
    force dut.pkt_cnt_o = 32'hFFFF_FFFF;
    @(posedge clk_i);
    #1;
    release dut.pkt_cnt_o;
    build_exp(1, 16'h0630, 1'b0, 1'b0);
    drive_pkt(1, 16'h0630, 1'b0, 1'b0, 1'b1);
    idle();
    drain();
    chk("cnt_wrap", 64'(pkt_cnt_o), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
